// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and WB.
// Drives a req/ack data-memory port with byte-lane stores and
// sign/zero-extended loads, keeps the HI/LO registers, selects the
// write-back value and registers it into the MEM/WB boundary.
// Optional build macro MEM_STALL_CNT_EN adds a busy-cycle counter
// (stall_cnt) and a slow-load pulse (load_use_hit).
module mem_stage #(
  parameter int PC_BITS   = 32,
  parameter int IR_BITS   = 32,
  parameter int DATA_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_BITS-1:0] PC_in,
  input  logic [IR_BITS-1:0] IR_in,
  input  logic [31:0]        result_1,
  input  logic [31:0]        result_2,
  input  logic [31:0]        regfile_out2,
  input  logic [5:0]         write,
  input  logic               MemToReg,
  input  logic               MemWrite,
  input  logic               RegWrite,
  input  logic               Jal,
  input  logic               ToLH,
  input  logic               ExtrSigned,
  input  logic               Sh,
  input  logic               Sb,
  input  logic               ld,
  input  logic [1:0]         ExtrWord,
  input  logic [1:0]         LHToReg,
  output logic               mem_req,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [3:0]         mem_be,
  output logic [31:0]        mem_wdata,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata,
  output logic               mem_busy,
  output logic [PC_BITS-1:0] wb_PC,
  output logic [IR_BITS-1:0] wb_IR,
  output logic [31:0]        wb_data,
  output logic [5:0]         wb_write,
  output logic               wb_RegWrite
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [0:0]         load_use_hit
`endif
);

  localparam int unsigned W = DATA_BITS;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state;

  // Holding registers: keep the request stable while waiting for ack.
  logic [W-1:0] hold_addr;
  logic [W-1:0] hold_wdata;
  logic [3:0]   hold_be;
  logic         hold_we;
  logic [1:0]   hold_lane;

  logic [W-1:0] hi;
  logic [W-1:0] lo;

  logic         valid;
  logic         mem_op;
  logic [1:0]   lane;
  logic [1:0]   eff_lane;
  logic [3:0]   cur_be;
  logic [W-1:0] cur_wdata;
  logic [W-1:0] cur_addr;
  logic [7:0]   ld_byte;
  logic [15:0]  ld_half;
  logic [W-1:0] ld_val;
  logic [W-1:0] pc_plus4;
  logic [W-1:0] wb_next;

  assign valid    = |IR_in;
  assign mem_op   = valid & (MemToReg | MemWrite);
  assign lane     = result_1[1:0];
  assign cur_addr = {result_1[31:2], 2'b00};
  assign pc_plus4 = 32'(PC_in) + 32'd4;

  // Store lane enables and lane-replicated write data for the current op.
  always_comb begin
    cur_be    = 4'b1111;
    cur_wdata = regfile_out2;
    if (MemWrite) begin
      if (Sb) begin
        cur_be    = 4'b0001 << lane;
        cur_wdata = {4{regfile_out2[7:0]}};
      end else if (Sh) begin
        cur_be    = lane[1] ? 4'b1100 : 4'b0011;
        cur_wdata = {2{regfile_out2[15:0]}};
      end
    end
  end

  // Memory port: live values in IDLE, held values while waiting.
  always_comb begin
    mem_req   = 1'b0;
    mem_busy  = 1'b0;
    mem_addr  = cur_addr;
    mem_be    = cur_be;
    mem_wdata = cur_wdata;
    mem_we    = mem_op & MemWrite;
    eff_lane  = lane;
    if (state == S_WAIT) begin
      mem_addr  = hold_addr;
      mem_be    = hold_be;
      mem_wdata = hold_wdata;
      mem_we    = hold_we;
      eff_lane  = hold_lane;
    end
    if (!rst) begin
      mem_req  = (state == S_WAIT) | mem_op;
      mem_busy = mem_op & ~mem_ack;
    end
  end

  // Load extraction: pick the byte/half at the lane, then extend.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    unique case (eff_lane)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = eff_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (ExtrWord)
      2'b01:   ld_val = {{24{ExtrSigned & ld_byte[7]}}, ld_byte};
      2'b10:   ld_val = {{16{ExtrSigned & ld_half[15]}}, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  // Write-back value selection in priority order.
  always_comb begin
    wb_next = result_1;
    if (Jal) begin
      wb_next = pc_plus4;
    end else if (MemToReg) begin
      wb_next = ld_val;
    end else if (LHToReg == 2'b01) begin
      wb_next = lo;
    end else if (LHToReg == 2'b10) begin
      wb_next = hi;
    end
  end

  // Access FSM plus capture of the request into the holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_be    <= '0;
      hold_we    <= 1'b0;
      hold_lane  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (mem_op) begin
            hold_addr  <= cur_addr;
            hold_wdata <= cur_wdata;
            hold_be    <= cur_be;
            hold_we    <= MemWrite;
            hold_lane  <= lane;
            if (!mem_ack) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) state <= S_IDLE;
        end
      endcase
    end
  end

  // HI/LO update when a ToLH instruction retires; readers this cycle see old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (valid && ToLH && !mem_busy) begin
      lo <= result_1;
      hi <= result_2;
    end
  end

  // MEM/WB boundary register: bubble while stalled, else the current instruction.
  always_ff @(posedge clk) begin
    if (rst || mem_busy) begin
      wb_PC       <= '0;
      wb_IR       <= '0;
      wb_data     <= '0;
      wb_write    <= '0;
      wb_RegWrite <= 1'b0;
    end else begin
      wb_PC       <= PC_in;
      wb_IR       <= IR_in;
      wb_data     <= wb_next;
      wb_write    <= write;
      wb_RegWrite <= RegWrite & valid;
    end
  end

`ifdef MEM_STALL_CNT_EN
  // Busy-cycle counter and pulse for loads that needed a wait state.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt    <= '0;
      load_use_hit <= '0;
    end else begin
      if (mem_busy) stall_cnt <= stall_cnt + 32'd1;
      load_use_hit <= ld & mem_op & (state == S_WAIT) & mem_ack;
    end
  end
`else
  logic unused_ld;
  assign unused_ld = ld;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// behavioural model of the write-back value, byte lanes and HI/LO.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_in, IR_in, result_1, result_2, regfile_out2;
  logic [5:0]  write;
  logic        MemToReg, MemWrite, RegWrite, Jal, ToLH, ExtrSigned, Sh, Sb, ld;
  logic [1:0]  ExtrWord, LHToReg;
  logic        mem_req, mem_we, mem_ack, mem_busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] wb_PC, wb_IR, wb_data;
  logic [5:0]  wb_write;
  logic        wb_RegWrite;

  int errors = 0;
  int checks = 0;
  logic [31:0] hi_m = 0;
  logic [31:0] lo_m = 0;

  mem_stage #(.PC_BITS(32), .IR_BITS(32), .DATA_BITS(32)) dut (
    .clk(clk), .rst(rst), .PC_in(PC_in), .IR_in(IR_in),
    .result_1(result_1), .result_2(result_2), .regfile_out2(regfile_out2),
    .write(write), .MemToReg(MemToReg), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .Jal(Jal), .ToLH(ToLH), .ExtrSigned(ExtrSigned),
    .Sh(Sh), .Sb(Sb), .ld(ld), .ExtrWord(ExtrWord), .LHToReg(LHToReg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_busy(mem_busy), .wb_PC(wb_PC), .wb_IR(wb_IR), .wb_data(wb_data),
    .wb_write(wb_write), .wb_RegWrite(wb_RegWrite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb_bubble(input string tag);
    chk({tag, ".wb_IR"}, wb_IR, 0);
    chk({tag, ".wb_RegWrite"}, 32'(wb_RegWrite), 0);
    chk({tag, ".wb_data"}, wb_data, 0);
    chk({tag, ".wb_PC"}, wb_PC, 0);
    chk({tag, ".wb_write"}, 32'(wb_write), 0);
  endtask

  task automatic idle_inputs();
    PC_in = 0; IR_in = 0; result_1 = 0; result_2 = 0; regfile_out2 = 0;
    write = 0; MemToReg = 0; MemWrite = 0; RegWrite = 0; Jal = 0; ToLH = 0;
    ExtrSigned = 0; Sh = 0; Sb = 0; ld = 0; ExtrWord = 0; LHToReg = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  // Reference for the value a load delivers, from lane/size rules.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] addr,
                                             input logic [1:0] size, input logic sgn);
    logic [31:0] v;
    int unsigned l;
    l = addr % 4;
    if (size == 2'b01) begin
      v = (rd >> (8 * l)) & 32'hFF;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'b10) begin
      v = (rd >> (16 * (l / 2))) & 32'hFFFF;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Drive one instruction, optionally stall it wt cycles, and check every cycle.
  task automatic run_op(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] rs2,
                        input logic [5:0] wr, input logic m2r, input logic mw, input logic rw,
                        input logic jl, input logic tolh, input logic sgn, input logic sh_i,
                        input logic sb_i, input logic [1:0] ew, input logic [1:0] lh,
                        input int wt, input logic [31:0] rd);
    logic        memop;
    logic [31:0] exp_data, exp_wd;
    logic [3:0]  exp_be;
    int unsigned l;
    @(negedge clk);
    PC_in = pc; IR_in = ir; result_1 = r1; result_2 = r2; regfile_out2 = rs2;
    write = wr; MemToReg = m2r; MemWrite = mw; RegWrite = rw; Jal = jl; ToLH = tolh;
    ExtrSigned = sgn; Sh = sh_i; Sb = sb_i; ld = m2r; ExtrWord = ew; LHToReg = lh;
    mem_ack = 0; mem_rdata = $urandom;
    memop = (ir != 0) && (m2r || mw);
    l = r1 % 4;
    exp_be = 4'hF; exp_wd = rs2;
    if (sb_i) begin
      exp_be = 4'(1 << l); exp_wd = (rs2 & 32'hFF) * 32'h0101_0101;
    end else if (sh_i) begin
      exp_be = (l >= 2) ? 4'hC : 4'h3; exp_wd = (rs2 & 32'hFFFF) * 32'h0001_0001;
    end
    if (jl) exp_data = pc + 4;
    else if (m2r) exp_data = model_load(rd, r1, ew, sgn);
    else if (lh == 2'b01) exp_data = lo_m;
    else if (lh == 2'b10) exp_data = hi_m;
    else exp_data = r1;
    if (!memop) begin
      #1;
      chk({tag, ".req"}, 32'(mem_req), 0);
      chk({tag, ".busy"}, 32'(mem_busy), 0);
      @(posedge clk); #1;
      chk({tag, ".wb_IR"}, wb_IR, ir);
      chk({tag, ".wb_RegWrite"}, 32'(wb_RegWrite), 32'(rw && ir != 0));
      if (ir != 0) begin
        chk({tag, ".wb_data"}, wb_data, exp_data);
        chk({tag, ".wb_write"}, 32'(wb_write), 32'(wr));
        chk({tag, ".wb_PC"}, wb_PC, pc);
      end
    end else begin
      for (int c = 0; c <= wt; c++) begin
        if (c > 0) @(negedge clk);
        if (c == wt) begin
          mem_ack = 1; mem_rdata = rd;
        end else begin
          mem_rdata = $urandom;
        end
        #1;
        chk({tag, ".req"}, 32'(mem_req), 1);
        chk({tag, ".busy"}, 32'(mem_busy), 32'(c != wt));
        chk({tag, ".addr"}, mem_addr, r1 & 32'hFFFF_FFFC);
        chk({tag, ".we"}, 32'(mem_we), 32'(mw));
        if (mw) begin
          chk({tag, ".be"}, 32'(mem_be), 32'(exp_be));
          chk({tag, ".wdata"}, mem_wdata, exp_wd);
        end
        @(posedge clk); #1;
        if (c != wt) begin
          chk({tag, ".stall_wb_IR"}, wb_IR, 0);
          chk({tag, ".stall_wb_RegWrite"}, 32'(wb_RegWrite), 0);
        end else begin
          chk({tag, ".wb_IR"}, wb_IR, ir);
          chk({tag, ".wb_RegWrite"}, 32'(wb_RegWrite), 32'(rw));
          chk({tag, ".wb_data"}, wb_data, exp_data);
          chk({tag, ".wb_write"}, 32'(wb_write), 32'(wr));
        end
      end
    end
    if (tolh && ir != 0) begin
      lo_m = r1; hi_m = r2;
    end
  endtask

  initial begin
    int kind, sz, wt;
    logic [31:0] ir, r1;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.req", 32'(mem_req), 0);
    chk("reset.busy", 32'(mem_busy), 0);
    chk_wb_bubble("reset");
    @(negedge clk); rst = 0;

    // Directed steps
    run_op("alu", 32'h100, 32'h0022_1820, 32'h1234, 0, 0, 6'd3,
           0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    run_op("lb_signed", 32'h104, 32'h8000_0001, 32'h103, 0, 0, 6'd4,
           1, 0, 1, 0, 0, 1, 0, 0, 2'b01, 2'b00, 3, 32'h80FF_0000);
    run_op("sh", 32'h108, 32'hA000_0002, 32'h202, 0, 32'hAAAA_BEEF, 6'd0,
           0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
    run_op("tolh", 32'h10C, 32'h0000_0019, 32'd5, 32'd7, 0, 6'd0,
           0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    run_op("mfhi", 32'h110, 32'h0000_1010, 32'd99, 0, 0, 6'd8,
           0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0);
    run_op("mflo", 32'h114, 32'h0000_1012, 32'd99, 0, 0, 6'd9,
           0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0);
    run_op("jal", 32'h400, 32'h0C00_0000, 32'h55, 0, 0, 6'd31,
           0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    run_op("bubble", 32'h500, 32'h0, 32'h204, 0, 0, 6'd5,
           1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    run_op("lhu_hi", 32'h118, 32'h8400_0003, 32'h307, 0, 0, 6'd6,
           1, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 32'h9876_5432);

    // Randomized instruction mix
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 6);
      ir = $urandom | 32'h1;
      r1 = $urandom;
      wt = $urandom_range(0, 3);
      sz = $urandom_range(0, 2);
      case (kind)
        0: run_op("r_alu", $urandom, ir, r1, $urandom, $urandom, 6'($urandom),
                  0, 0, 1'($urandom), 0, 0, 1'($urandom), 0, 0, 2'($urandom_range(0, 2)), 2'b00, 0, 0);
        1: run_op("r_load", $urandom, ir, r1, $urandom, $urandom, 6'($urandom),
                  1, 0, 1, 0, 0, 1'($urandom), 0, 0, 2'(sz), 2'b00, wt, $urandom);
        2: run_op("r_store", $urandom, ir, r1, $urandom, $urandom, 6'($urandom),
                  0, 1, 0, 0, 0, 0, 1'(sz == 2), 1'(sz == 1), 2'b00, 2'b00, wt, $urandom);
        3: run_op("r_tolh", $urandom, ir, r1, $urandom, $urandom, 6'($urandom),
                  0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        4: run_op("r_mflh", $urandom, ir, r1, $urandom, $urandom, 6'($urandom),
                  0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'($urandom_range(1, 2)), 0, 0);
        5: run_op("r_jal", $urandom, ir, r1, $urandom, $urandom, 6'($urandom),
                  0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        default: run_op("r_bubble", $urandom, 32'h0, r1, $urandom, $urandom, 6'($urandom),
                  1'($urandom), 1'($urandom), 1, 0, 1'($urandom), 0, 0, 0, 2'b00, 2'b00, 0, 0);
      endcase
    end

    // Reset while waiting for ack abandons the request; stale ack is ignored.
    run_op("pre_rst_tolh", 32'h600, 32'h0000_0019, 32'h1111, 32'h2222, 0, 6'd0,
           0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    PC_in = 32'h700; IR_in = 32'h8C00_0001; result_1 = 32'h40; write = 6'd2;
    MemToReg = 1; ld = 1; RegWrite = 1; ToLH = 0; Jal = 0; LHToReg = 0; mem_ack = 0;
    #1;
    chk("rstwait.busy", 32'(mem_busy), 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rstwait.req_in_rst", 32'(mem_req), 0);
    chk("rstwait.busy_in_rst", 32'(mem_busy), 0);
    @(posedge clk); #1;
    chk_wb_bubble("rstwait");
    @(negedge clk);
    idle_inputs();
    rst = 0; mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    hi_m = 0; lo_m = 0;
    #1;
    chk("stale_ack.req", 32'(mem_req), 0);
    chk("stale_ack.busy", 32'(mem_busy), 0);
    @(posedge clk); #1;
    chk("stale_ack.wb_RegWrite", 32'(wb_RegWrite), 0);
    chk("stale_ack.wb_IR", wb_IR, 0);
    run_op("post_rst_mfhi", 32'h800, 32'h0000_1010, 32'h3, 0, 0, 6'd7,
           0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0);
    run_op("post_rst_mflo", 32'h804, 32'h0000_1012, 32'h3, 0, 0, 6'd7,
           0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
